fifo_wr_ctrl: RTL and testbench

Write-side pointer and flag controller for the UART async FIFO, running in the write (producer) clock domain. It accepts write requests, drives the dual-port memory write address and strobe, and owns the binary and Gray write pointers. It publishes the registered Gray write pointer to the 4-bit pointer synchronizer feeding the read domain. It consumes that synchronizer's counterpart output, the read Gray pointer already synchronized into this domain, to derive full, almost-full, fill level and overflow.

---
 rtl/fifo_wr_ctrl.sv | 106 ++++++++++
 tb/tb_fifo_wr_ctrl.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/fifo_wr_ctrl.sv
// Write-domain pointer/flag controller for the UART async FIFO.
// Optional level/almost-full logic is built only when FIFO_WR_LEVEL_EN is defined.
module fifo_wr_ctrl #(
    parameter int DATA_WIDTH   = 8,
    parameter int ADDR_WIDTH   = 3,
    parameter int AFULL_THRESH = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_inc,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [ADDR_WIDTH:0]   sync_rd_ptr,
    input  logic                  ovf_clr,
    output logic                  wr_en_mem,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [DATA_WIDTH-1:0] wr_data_mem,
    output logic [ADDR_WIDTH:0]   wr_gray_ptr,
    output logic                  full,
    output logic                  almost_full,
    output logic [ADDR_WIDTH:0]   wr_level,
    output logic                  overflow
);

    localparam int PW = ADDR_WIDTH + 1;

    logic [PW-1:0] wbin_q, wbin_d;
    logic [PW-1:0] wgray_q, wgray_d;
    logic [PW-1:0] rd_full_cmp;
    logic          full_q, full_d;
    logic          ovf_q, ovf_d;
    logic          accept;

    // Decision is taken on the registered flag; an in-reset request never strobes.
    assign accept = wr_inc && !full_q && rst;

    assign wbin_d  = accept ? wbin_q + PW'(1) : wbin_q;
    assign wgray_d = wbin_d ^ (wbin_d >> 1);

    // Full when the write pointer is exactly one lap ahead of the read pointer.
    assign rd_full_cmp = {~sync_rd_ptr[PW-1:PW-2], sync_rd_ptr[PW-3:0]};
    assign full_d      = (wgray_d == rd_full_cmp);

    always_comb begin
        ovf_d = ovf_q;
        if (ovf_clr)
            ovf_d = 1'b0;
        if (wr_inc && full_q)
            ovf_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wbin_q  <= '0;
            wgray_q <= '0;
            full_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            wbin_q  <= wbin_d;
            wgray_q <= wgray_d;
            full_q  <= full_d;
            ovf_q   <= ovf_d;
        end
    end

`ifdef FIFO_WR_LEVEL_EN
    localparam logic [PW-1:0] AF_TH = PW'(AFULL_THRESH);

    logic [PW-1:0] rbin;
    logic [PW-1:0] level_q, level_d;
    logic          afull_q, afull_d;

    always_comb begin
        rbin = '0;
        for (int i = 0; i < PW; i++)
            rbin[i] = ^(sync_rd_ptr >> i);
    end

    // Read pointer lags through the synchronizer, so this over-reports, never under.
    assign level_d = wbin_d - rbin;
    assign afull_d = (level_d >= AF_TH);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            level_q <= '0;
            afull_q <= 1'b0;
        end else begin
            level_q <= level_d;
            afull_q <= afull_d;
        end
    end

    assign wr_level    = level_q;
    assign almost_full = afull_q;
`else
    assign wr_level    = '0;
    assign almost_full = 1'b0;
`endif

    assign wr_en_mem   = accept;
    assign wr_addr     = wbin_q[ADDR_WIDTH-1:0];
    assign wr_data_mem = wr_data;
    assign wr_gray_ptr = wgray_q;
    assign full        = full_q;
    assign overflow    = ovf_q;

endmodule

// File: tb/tb_fifo_wr_ctrl.sv
// Scoreboard bench for fifo_wr_ctrl: occupancy model built from write/read counts.
module tb_fifo_wr_ctrl;

    localparam int DW = 8;
    localparam int AW = 3;
    localparam int DEPTH = 8;
    localparam int AF = 6;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          wr_inc = 1'b0;
    logic [DW-1:0] wr_data = '0;
    logic [AW:0]   sync_rd_ptr = '0;
    logic          ovf_clr = 1'b0;
    logic          wr_en_mem;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data_mem;
    logic [AW:0]   wr_gray_ptr;
    logic          full;
    logic          almost_full;
    logic [AW:0]   wr_level;
    logic          overflow;

    fifo_wr_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .AFULL_THRESH(AF)) dut (
        .clk(clk), .rst(rst), .wr_inc(wr_inc), .wr_data(wr_data),
        .sync_rd_ptr(sync_rd_ptr), .ovf_clr(ovf_clr), .wr_en_mem(wr_en_mem),
        .wr_addr(wr_addr), .wr_data_mem(wr_data_mem), .wr_gray_ptr(wr_gray_ptr),
        .full(full), .almost_full(almost_full), .wr_level(wr_level), .overflow(overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          en;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic [AW:0]   gray;
        logic          full;
        logic [AW:0]   level;
        logic          afull;
        logic          ovf;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    bit   gray_prev_ok = 1'b0;
    logic [AW:0] gray_prev;

    // Model state: total accepted writes and the read count the bench publishes.
    int m_wr = 0, m_rd = 0;
    bit m_full = 0, m_afull = 0, m_ovf = 0;
    int m_level = 0;

    function automatic logic [AW:0] to_gray(int n);
        int b;
        b = n % (2 * DEPTH);
        return (AW + 1)'(b ^ (b / 2));
    endfunction

    task automatic chk(string name, int act, int exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_wr = 0; m_rd = 0; m_full = 0; m_afull = 0; m_ovf = 0; m_level = 0;
    endtask

    // One request cycle: drive inputs after the edge, record what must be seen.
    task automatic cycle(bit inc, bit clr, int rd_n);
        exp_t e;
        bit   acc;
        @(posedge clk);
        #1;
        wr_inc      = inc;
        ovf_clr     = clr;
        wr_data     = DW'($urandom);
        m_rd        = rd_n;
        sync_rd_ptr = to_gray(m_rd);
        acc         = inc && !m_full;
        e.en    = acc;
        e.addr  = AW'(m_wr % DEPTH);
        e.data  = wr_data;
        e.gray  = to_gray(m_wr);
        e.full  = m_full;
        e.level = (AW + 1)'(m_level);
        e.afull = m_afull;
        e.ovf   = m_ovf;
        exp_q.push_back(e);
        if (inc && m_full) m_ovf = 1;
        else if (clr)      m_ovf = 0;
        if (acc) m_wr++;
        m_full = (m_wr - m_rd) == DEPTH;
`ifdef FIFO_WR_LEVEL_EN
        m_level = m_wr - m_rd;
        m_afull = m_level >= AF;
`endif
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("wr_en_mem",   wr_en_mem,   e.en);
            if (e.en) begin
                chk("wr_addr",     wr_addr,     e.addr);
                chk("wr_data_mem", wr_data_mem, e.data);
            end
            chk("wr_gray_ptr", wr_gray_ptr, e.gray);
            chk("full",        full,        e.full);
            chk("wr_level",    wr_level,    e.level);
            chk("almost_full", almost_full, e.afull);
            chk("overflow",    overflow,    e.ovf);
            if (gray_prev_ok)
                chk("gray_one_bit_step", ($countones(wr_gray_ptr ^ gray_prev) <= 1), 1);
            gray_prev    = wr_gray_ptr;
            gray_prev_ok = 1'b1;
        end
    end

    task automatic chk_all_zero(string tag);
        chk({tag, "_strobe"}, wr_en_mem,   0);
        chk({tag, "_gray"},   wr_gray_ptr, 0);
        chk({tag, "_addr"},   wr_addr,     0);
        chk({tag, "_full"},   full,        0);
        chk({tag, "_afull"},  almost_full, 0);
        chk({tag, "_level"},  wr_level,    0);
        chk({tag, "_ovf"},    overflow,    0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lo;
        #2;
        chk_all_zero("reset");
        #20 rst = 1'b1;

        // Fill from empty, then hold one idle cycle to observe full.
        for (int i = 0; i < 8; i++) cycle(1, 0, 0);
        cycle(0, 0, 0);
        // Overflow: dropped write, set beats clear, then clear alone.
        cycle(1, 0, 0);
        cycle(1, 1, 0);
        cycle(0, 1, 0);
        cycle(0, 0, 0);
        // Release by one read, then the next write lands on address 0.
        cycle(0, 0, 1);
        cycle(1, 0, 1);
        cycle(0, 0, m_wr);
        // Almost-full threshold crossing from empty.
        for (int i = 0; i < 6; i++) cycle(1, 0, m_rd);
        cycle(0, 0, m_rd);
        cycle(0, 0, m_wr);
        // Wrap with the read pointer trailing by two.
        for (int i = 0; i < 20; i++) cycle(1, 0, (m_wr - 2 > m_rd) ? m_wr - 2 : m_rd);
        cycle(0, 0, m_wr);
        // Random traffic: read count only ever advances up to the write count.
        for (int i = 0; i < 400; i++) begin
            lo = m_rd;
            cycle(($urandom_range(0, 3) != 0), ($urandom_range(0, 7) == 0),
                  ($urandom_range(0, 2) == 0) ? $urandom_range(lo, m_wr) : lo);
        end
        cycle(0, 1, m_wr);
        cycle(0, 0, m_wr);
        // Reset mid-fill, asserted between edges with a write request pending.
        for (int i = 0; i < 5; i++) cycle(1, 0, m_rd);
        @(posedge clk);
        #1;
        wr_inc = 1'b1;
        #1;
        rst = 1'b0;
        #1;
        chk_all_zero("midreset");
        model_reset();
        gray_prev_ok = 1'b0;
        sync_rd_ptr  = '0;
        wr_inc       = 1'b0;
        #1;
        rst = 1'b1;
        cycle(1, 0, 0);
        cycle(1, 0, 0);
        cycle(0, 0, 0);
        @(posedge clk);
        @(negedge clk);
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
